audio_mixer: RTL

- Four-channel audio mixer in the clk32 domain, feeding the 16-bit left/right inputs of the I2S codec output block.
- Replaces the purely combinational A+C / B+D sum with a gain-scaled, saturating mix, time-multiplexed on one multiplier.
- Each mix is triggered by the codec sample clock, which comes from the clk25 domain.
- Output samples stay stable for the rest of each sample period.

---
 rtl/audio_mixer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/audio_mixer.sv
// Four-channel gain-scaled saturating mixer: one shared multiplier, mix started by the synchronised codec sample clock.
// Outputs update 5 cycles after the start edge and hold until the next mix; a start while busy is dropped and flagged as overrun.
module audio_mixer #(
  parameter int CH_W   = 16,
  parameter int GAIN_W = 8,
  parameter int UNITY  = 128
) (
  input  logic                   clk32,
  input  logic                   rst,
  input  logic signed [CH_W-1:0] channel_a_i,
  input  logic signed [CH_W-1:0] channel_b_i,
  input  logic signed [CH_W-1:0] channel_c_i,
  input  logic signed [CH_W-1:0] channel_d_i,
  input  logic                   sample_clk_i,
  input  logic                   cfg_wr_i,
  input  logic [1:0]             cfg_addr_i,
  input  logic [GAIN_W-1:0]      cfg_data_i,
  input  logic                   mute_i,
  input  logic                   ovr_clr_i,
  output logic signed [CH_W-1:0] left_o,
  output logic signed [CH_W-1:0] right_o,
  output logic                   mix_valid_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int PROD_W = CH_W + GAIN_W + 1;
  localparam int ACC_W  = CH_W + 3;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (CH_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [2:0] {IDLE, MUL_A, MUL_C, MUL_B, MUL_D, SAT} state_t;

  state_t                   state;
  logic                     sync1, sync2, sync3;
  logic                     start;
  logic [GAIN_W-1:0]        gain [4];
  logic signed [CH_W-1:0]   hold_ch [4];
  logic [GAIN_W-1:0]        hold_g [4];
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic signed [CH_W-1:0]   mul_ch;
  logic [GAIN_W-1:0]        mul_g;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  scaled;

  assign start = sync2 & ~sync3;

  function automatic logic signed [CH_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > MAX_V)      return MAX_V[CH_W-1:0];
    else if (v < MIN_V) return MIN_V[CH_W-1:0];
    else                return v[CH_W-1:0];
  endfunction

  // Holding-register index 0..3 = A, B, C, D; the state picks the operand pair.
  always_comb begin
    mul_ch = hold_ch[0];
    mul_g  = hold_g[0];
    case (state)
      MUL_C:   begin mul_ch = hold_ch[2]; mul_g = hold_g[2]; end
      MUL_B:   begin mul_ch = hold_ch[1]; mul_g = hold_g[1]; end
      MUL_D:   begin mul_ch = hold_ch[3]; mul_g = hold_g[3]; end
      default: begin mul_ch = hold_ch[0]; mul_g = hold_g[0]; end
    endcase
  end

  assign prod   = mul_ch * $signed({1'b0, mul_g});
  assign scaled = ACC_W'(prod >>> (GAIN_W - 1));

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sample_clk_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) gain[i] <= GAIN_W'(UNITY);
    end else if (cfg_wr_i) begin
      gain[cfg_addr_i] <= cfg_data_i;
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc_l       <= '0;
      acc_r       <= '0;
      left_o      <= '0;
      right_o     <= '0;
      mix_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold_ch[i] <= '0;
        hold_g[i]  <= '0;
      end
    end else begin
      mix_valid_o <= 1'b0;
      // Set beats clear when both land in the same cycle.
      if (start && state != IDLE) overrun_o <= 1'b1;
      else if (ovr_clr_i)         overrun_o <= 1'b0;
      case (state)
        IDLE: if (start) begin
          hold_ch[0] <= channel_a_i;
          hold_ch[1] <= channel_b_i;
          hold_ch[2] <= channel_c_i;
          hold_ch[3] <= channel_d_i;
          for (int i = 0; i < 4; i++) hold_g[i] <= gain[i];
          busy_o <= 1'b1;
          state  <= MUL_A;
        end
        MUL_A: begin acc_l <= scaled;         state <= MUL_C; end
        MUL_C: begin acc_l <= acc_l + scaled; state <= MUL_B; end
        MUL_B: begin acc_r <= scaled;         state <= MUL_D; end
        MUL_D: begin acc_r <= acc_r + scaled; state <= SAT;   end
        SAT: begin
          left_o      <= mute_i ? '0 : saturate(acc_l);
          right_o     <= mute_i ? '0 : saturate(acc_r);
          mix_valid_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
